// File: rtl/fetch_unit_if.sv
// Memory read port of the instruction fetch unit: request/address out, grant and
// read response in.
interface fetch_unit_if;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_rd_gnt;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_addr,
        input  mem_rd_gnt,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_addr,
        output mem_rd_gnt,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: issues one memory read per request,
// captures the word into the instruction register, and handles flush and timeout.
module fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_IR       = 32'h0000_0013
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               fetch_req_i,
    input  logic [31:0]        pc_i,
    input  logic               flush_i,
    fetch_unit_if.master       mem,
    output logic [31:0]        ir_o,
    output logic               ir_valid_o,
    output logic               busy_o,
    output logic               misaligned_o,
    output logic               timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_e;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        ir_load;
    logic        ir_valid_d, misaligned_d, timeout_d;

    assign cnt_inc = cnt_q + 16'd1;

    assign mem.mem_rd_req = (state_q == S_REQ);
    assign mem.mem_addr   = addr_q;
    assign busy_o         = (state_q != S_IDLE);

    // NOTE: every signal gets its default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        ir_load      = 1'b0;
        ir_valid_d   = 1'b0;
        misaligned_d = 1'b0;
        timeout_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fetch_req_i) begin
                    if (pc_i[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d  = pc_i;
                        state_d = S_REQ;
                    end
                end
            end

            // A flush cancels the request even if the grant lands in the same cycle.
            S_REQ: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (mem.mem_rd_gnt) begin
                    cnt_d   = 16'd0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (mem.mem_rd_valid) begin
                    state_d = S_IDLE;
                    if (!flush_i) begin
                        ir_load    = 1'b1;
                        ir_valid_d = 1'b1;
                    end
                end else if (cnt_inc == TIMEOUT_LIMIT) begin
                    cnt_d     = cnt_inc;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (flush_i) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            // The flushed read is still in flight; swallow its response.
            S_DRAIN: begin
                if (mem.mem_rd_valid) begin
                    state_d = S_IDLE;
                end else if (cnt_inc == TIMEOUT_LIMIT) begin
                    cnt_d     = cnt_inc;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            cnt_q        <= 16'd0;
            ir_o         <= RESET_IR;
            ir_valid_o   <= 1'b0;
            misaligned_o <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            ir_valid_o   <= ir_valid_d;
            misaligned_o <= misaligned_d;
            timeout_o    <= timeout_d;
            if (ir_load) begin
                ir_o <= mem.mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// transactions scored against a per-transaction outcome model.
module tb_fetch_unit;

    localparam int          T   = 4;
    localparam logic [31:0] RIR = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fetch_req_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] ir_o;
    logic        ir_valid_o;
    logic        busy_o;
    logic        misaligned_o;
    logic        timeout_o;

    fetch_unit_if mem ();

    fetch_unit #(
        .TIMEOUT_CYCLES(T),
        .RESET_IR      (RIR)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .fetch_req_i (fetch_req_i),
        .pc_i        (pc_i),
        .flush_i     (flush_i),
        .mem         (mem),
        .ir_o        (ir_o),
        .ir_valid_o  (ir_valid_o),
        .busy_o      (busy_o),
        .misaligned_o(misaligned_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [31:0] exp_ir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic quiet_inputs();
        fetch_req_i      = 1'b0;
        flush_i          = 1'b0;
        mem.mem_rd_gnt   = 1'b0;
        mem.mem_rd_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        exp_ir  = RIR;
    endtask

    // One fetch. g: REQ cycles before grant; fr: REQ cycle index carrying flush
    // (-1 none); k: WAIT cycle of the response (1 = cycle after grant);
    // fw: cycle after grant carrying flush (0 none). noise drives inputs that
    // must be ignored in the current state.
    task automatic run_txn(input logic [31:0] pc, input int g, input int fr,
                           input int k, input int fw, input logic [31:0] data,
                           input bit noise);
        int  end_cyc;
        bit  captured;
        bit  timed_out;

        check("idle_busy", busy_o, 1'b0);
        check("idle_req", mem.mem_rd_req, 1'b0);
        fetch_req_i = 1'b1;
        pc_i        = pc;
        cyc();
        fetch_req_i = 1'b0;

        if (pc[1:0] != 2'b00) begin
            check("mis_pulse", misaligned_o, 1'b1);
            check("mis_busy", busy_o, 1'b0);
            check("mis_req", mem.mem_rd_req, 1'b0);
            check("mis_ir", ir_o, exp_ir);
            cyc();
            check("mis_clear", misaligned_o, 1'b0);
            check("mis_req2", mem.mem_rd_req, 1'b0);
            return;
        end
        check("mis_none", misaligned_o, 1'b0);

        for (int i = 0; i <= g; i++) begin
            check("req_high", mem.mem_rd_req, 1'b1);
            check("req_addr", mem.mem_addr, pc);
            check("req_busy", busy_o, 1'b1);
            mem.mem_rd_gnt = (i == g);
            flush_i        = (i == fr);
            if (noise) begin
                mem.mem_rd_valid = 1'($urandom_range(0, 1));
                mem.mem_rd_data  = $urandom;
                fetch_req_i      = 1'($urandom_range(0, 1));
                pc_i             = $urandom;
            end
            cyc();
            if (i == fr) break;
        end
        quiet_inputs();

        if (fr >= 0 && fr <= g) begin
            check("rflush_busy", busy_o, 1'b0);
            check("rflush_req", mem.mem_rd_req, 1'b0);
            check("rflush_irv", ir_valid_o, 1'b0);
            check("rflush_ir", ir_o, exp_ir);
            return;
        end

        // Outcome from the rules: response within T cycles wins, otherwise timeout at T.
        timed_out = (k > T);
        end_cyc   = timed_out ? T : k;
        captured  = !timed_out && (fw == 0 || fw > k);

        for (int j = 1; j <= end_cyc; j++) begin
            check("wait_req", mem.mem_rd_req, 1'b0);
            check("wait_busy", busy_o, 1'b1);
            check("wait_addr", mem.mem_addr, pc);
            check("wait_irv", ir_valid_o, 1'b0);
            check("wait_tmo", timeout_o, 1'b0);
            mem.mem_rd_valid = (j == k);
            mem.mem_rd_data  = (j == k) ? data : $urandom;
            flush_i          = (j == fw);
            if (noise) begin
                fetch_req_i = 1'($urandom_range(0, 1));
                pc_i        = $urandom;
            end
            cyc();
        end
        quiet_inputs();

        if (captured) exp_ir = data;
        check("end_busy", busy_o, 1'b0);
        check("end_irv", ir_valid_o, captured);
        check("end_tmo", timeout_o, timed_out);
        check("end_ir", ir_o, exp_ir);
        cyc();
        check("post_irv", ir_valid_o, 1'b0);
        check("post_tmo", timeout_o, 1'b0);
        check("post_ir", ir_o, exp_ir);
    endtask

    initial begin
        reset_i         = 1'b1;
        pc_i            = 32'd0;
        mem.mem_rd_data = 32'd0;
        quiet_inputs();
        cyc();
        pulse_reset();

        check("rst_ir", ir_o, RIR);
        check("rst_busy", busy_o, 1'b0);
        check("rst_irv", ir_valid_o, 1'b0);
        check("rst_mis", misaligned_o, 1'b0);
        check("rst_tmo", timeout_o, 1'b0);
        check("rst_req", mem.mem_rd_req, 1'b0);
        check("rst_addr", mem.mem_addr, 32'd0);

        // Minimum latency fetch, then a long grant wait.
        run_txn(32'h0000_0100, 0, -1, 1, 0, 32'h0050_0093, 1'b0);
        run_txn(32'h0000_0200, 5, -1, 3, 0, 32'h1234_5678, 1'b0);

        // Misaligned request right after reset keeps the reset instruction.
        pulse_reset();
        run_txn(32'h0000_0102, 0, -1, 1, 0, 32'h0, 1'b0);
        check("mis_ir_reset", ir_o, RIR);

        // Flush in WAIT, response two cycles later is drained.
        run_txn(32'h0000_0300, 0, -1, 3, 1, 32'hDEAD_BEEF, 1'b0);
        // Timeout, then a normal fetch.
        run_txn(32'h0000_0400, 1, -1, 100, 0, 32'h0, 1'b0);
        run_txn(32'h0000_0404, 0, -1, 2, 0, 32'hA5A5_0001, 1'b0);
        // Flush beats a same-cycle grant.
        run_txn(32'h0000_0500, 2, 2, 1, 0, 32'h0, 1'b0);
        // Response on the last allowed cycle wins over the timeout.
        run_txn(32'h0000_0600, 0, -1, T, 0, 32'h0BAD_F00D, 1'b0);
        // Flush together with the response discards it.
        run_txn(32'h0000_0604, 0, -1, 2, 2, 32'h7777_7777, 1'b0);

        // Reset in WAIT, stale response afterwards.
        fetch_req_i = 1'b1;
        pc_i        = 32'h0000_0700;
        cyc();
        fetch_req_i    = 1'b0;
        mem.mem_rd_gnt = 1'b1;
        cyc();
        mem.mem_rd_gnt = 1'b0;
        check("rw_busy", busy_o, 1'b1);
        pulse_reset();
        mem.mem_rd_valid = 1'b1;
        mem.mem_rd_data  = 32'hCAFE_F00D;
        check("rw_ir", ir_o, RIR);
        check("rw_busy0", busy_o, 1'b0);
        check("rw_addr", mem.mem_addr, 32'd0);
        cyc();
        mem.mem_rd_valid = 1'b0;
        check("rw_stale_ir", ir_o, RIR);
        check("rw_stale_irv", ir_valid_o, 1'b0);
        check("rw_stale_busy", busy_o, 1'b0);

        // Reset in REQ drops the request.
        fetch_req_i = 1'b1;
        pc_i        = 32'h0000_0800;
        cyc();
        fetch_req_i = 1'b0;
        check("rr_req", mem.mem_rd_req, 1'b1);
        pulse_reset();
        check("rr_req0", mem.mem_rd_req, 1'b0);
        check("rr_busy0", busy_o, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] pc;
            int          g, fr, k, fw;
            pc = $urandom;
            if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
            g  = $urandom_range(0, 4);
            fr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, g)) : -1;
            k  = $urandom_range(1, T + 2);
            if ($urandom_range(0, 2) == 0)
                fw = (k <= T) ? int'($urandom_range(1, k)) : int'($urandom_range(1, T - 1));
            else
                fw = 0;
            run_txn(pc, g, fr, k, fw, $urandom, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
